activity_scan_16: RTL

- Holds the 16-entry activity bitfield for one timestep and drains it in index order to the downstream compute stage.
- Upstream logic marks entries active with set_valid/set_idx. On step_start the block dispatches each active index, lowest first, over a valid/ready handshake.
- Selection uses the existing find_set_bit_16 priority encoder, which returns the lowest set index.
- Pulses step_done once the field for the current step is empty.

---
 rtl/activity_scan_16_pkg.sv | 19 +
 rtl/activity_scan_16_find_set_bit.sv | 22 ++
 rtl/activity_scan_16.sv | 110 +++++++++++
 3 files changed

// File: rtl/activity_scan_16_pkg.sv
// Shared types for the activity scan block: field/index widths and scan states.
package ucaspian_act_pkg;

   localparam int ACT_WIDTH = 16;
   localparam int ACT_IDX_W = 4;

   typedef logic [ACT_WIDTH-1:0] act_field_t;
   typedef logic [ACT_IDX_W-1:0] act_idx_t;

   typedef enum logic {ACT_IDLE, ACT_SCAN} act_scan_state_t;

   function automatic act_field_t idx_to_onehot(input act_idx_t idx);
      act_field_t f;
      f = '0;
      f[idx] = 1'b1;
      return f;
   endfunction

endpackage

// File: rtl/activity_scan_16_find_set_bit.sv
// Priority encoder: returns the lowest set index of a 16-bit field.
import ucaspian_act_pkg::*;

module find_set_bit_16 (
   input  act_field_t scan,
   output act_idx_t   out_idx,
   output logic       none_found
);

   // Walk from the top down so the lowest set bit is the last one written.
   always_comb begin
      out_idx    = '0;
      none_found = 1'b1;
      for (int i = ACT_WIDTH - 1; i >= 0; i--) begin
         if (scan[i]) begin
            out_idx    = act_idx_t'(i);
            none_found = 1'b0;
         end
      end
   end

endmodule

// File: rtl/activity_scan_16.sv
// Drains a 16-entry activity field lowest-index-first over valid/ready.
// Optional ACT_SCAN_COUNT_EN adds a per-scan dispatch counter output.
import ucaspian_act_pkg::*;

module activity_scan_16 #(
   parameter int SNAPSHOT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       set_valid,
   input  act_idx_t   set_idx,
   input  logic       clear_all,
   input  logic       step_start,
   output logic       busy,
   output logic       out_valid,
   output act_idx_t   out_idx,
   input  logic       out_ready,
   output logic       step_done
`ifdef ACT_SCAN_COUNT_EN
   ,
   output logic [4:0] dispatch_count
`endif
);

   act_scan_state_t r_state, w_stateNext;
   act_field_t      r_scan, w_scanNext, w_startField, w_setBit, w_clrBit;
   act_idx_t        w_encIdx;
   logic            w_noneFound, w_start, w_accept;

   find_set_bit_16 u_find (
      .scan       (r_scan),
      .out_idx    (w_encIdx),
      .none_found (w_noneFound)
   );

   assign w_start  = (r_state == ACT_IDLE) && step_start && !clear_all;
   assign w_accept = out_valid && out_ready && !clear_all;
   assign w_setBit = set_valid ? idx_to_onehot(set_idx) : '0;
   assign w_clrBit = w_accept ? idx_to_onehot(w_encIdx) : '0;

   assign busy      = (r_state == ACT_SCAN);
   assign out_valid = busy && !w_noneFound;
   assign out_idx   = busy ? w_encIdx : '0;
   assign step_done = busy && w_noneFound && !clear_all;

   // With snapshotting, sets land in a side buffer that is swapped in at start.
   generate
      if (SNAPSHOT != 0) begin : g_snapshot
         act_field_t r_pending;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               r_pending <= '0;
            else if (clear_all || w_start)
               r_pending <= '0;
            else
               r_pending <= r_pending | w_setBit;
         end
         assign w_startField = r_pending | w_setBit;
      end else begin : g_direct
         assign w_startField = r_scan | w_setBit;
      end
   endgenerate

   always_comb begin
      w_scanNext = r_scan & ~w_clrBit;
      if (clear_all)
         w_scanNext = '0;
      else if (w_start)
         w_scanNext = w_startField;
      else if (SNAPSHOT == 0)
         w_scanNext = (r_scan & ~w_clrBit) | w_setBit;
   end

   always_comb begin
      w_stateNext = r_state;
      if (clear_all)
         w_stateNext = ACT_IDLE;
      else if (w_start)
         w_stateNext = ACT_SCAN;
      else if ((r_state == ACT_SCAN) && w_noneFound)
         w_stateNext = ACT_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ACT_IDLE;
         r_scan  <= '0;
      end else begin
         r_state <= w_stateNext;
         r_scan  <= w_scanNext;
      end
   end

`ifdef ACT_SCAN_COUNT_EN
   logic [4:0] r_count;

   // Saturates only matters for the single-field build, where re-sets can exceed 16.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_count <= '0;
      else if (clear_all || w_start)
         r_count <= '0;
      else if (w_accept && (r_count != 5'd31))
         r_count <= r_count + 5'd1;
   end

   assign dispatch_count = r_count;
`endif

endmodule
